// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational 32-bit ALU between two requesters using
//            valid/ready command and response handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter bit FAIR  = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic             r_ptr;
    logic             r_owner;
    logic [2:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_rsp_data;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_idle;
    logic             w_grant1;
    logic             w_accept;
    logic             w_rsp_fire;
    logic [31:0]      w_alu_y;

    // Ready is masked by reset so it is low for the whole reset pulse.
    assign w_idle     = (r_state == c_S_IDLE) && !reset;
    assign w_grant1   = req1_valid && (!req0_valid || r_ptr);
    assign req0_ready = w_idle && req0_valid && !w_grant1;
    assign req1_ready = w_idle && w_grant1;
    assign w_accept   = req0_ready || req1_ready;

    assign rsp0_valid = (r_state == c_S_RESP) && !r_owner;
    assign rsp1_valid = (r_state == c_S_RESP) &&  r_owner;
    assign w_rsp_fire = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign busy     = (r_state == c_S_EXEC) || (r_state == c_S_RESP);
    assign rsp_data = r_rsp_data;
    assign cnt0     = r_cnt0;
    assign cnt1     = r_cnt1;

    // Shared ALU sees only the latched command.
    always_comb begin
        w_alu_y = r_a;
        case (r_op)
            3'b000:  w_alu_y = r_a;
            3'b001:  w_alu_y = r_a + r_b;
            3'b010:  w_alu_y = r_a - r_b;
            3'b011:  w_alu_y = r_a & r_b;
            3'b100:  w_alu_y = r_a | r_b;
            3'b101:  w_alu_y = r_a + 32'd1;
            3'b110:  w_alu_y = r_a - 32'd1;
            default: w_alu_y = r_b;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_ptr      <= 1'b0;
            r_owner    <= 1'b0;
            r_op       <= 3'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_rsp_data <= 32'd0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant1;
                        r_op    <= w_grant1 ? req1_op : req0_op;
                        r_a     <= w_grant1 ? req1_a  : req0_a;
                        r_b     <= w_grant1 ? req1_b  : req0_b;
                        r_state <= c_S_EXEC;
                    end
                end
                c_S_EXEC: begin
                    r_rsp_data <= w_alu_y;
                    r_state    <= c_S_RESP;
                end
                c_S_RESP: begin
                    if (w_rsp_fire) begin
                        if (r_owner) r_cnt1 <= r_cnt1 + c_CNT_ONE;
                        else         r_cnt0 <= r_cnt0 + c_CNT_ONE;
                        if (FAIR)    r_ptr  <= ~r_owner;
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed plus random checks of alu_arbiter in round-robin/16-bit
//            and fixed-priority/2-bit counter configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  r0v, r1v, rdy0, rdy1, rv0, rv1, rr0, rr1, bsy;
    logic [2:0]  op0 [2];
    logic [2:0]  op1 [2];
    logic [31:0] a0 [2];
    logic [31:0] b0 [2];
    logic [31:0] a1 [2];
    logic [31:0] b1 [2];
    logic [31:0] rd [2];
    logic [15:0] c0_d0, c1_d0;
    logic [1:0]  c0_d1, c1_d1;

    int checks = 0;
    int errors = 0;
    int m_ptr [2];
    int m_cnt0 [2];
    int m_cnt1 [2];
    int m_mod [2] = '{65536, 4};
    bit m_fair [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    alu_arbiter #(.FAIR(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset),
        .req0_valid(r0v[0]), .req0_ready(rdy0[0]), .req0_op(op0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
        .req1_valid(r1v[0]), .req1_ready(rdy1[0]), .req1_op(op1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
        .rsp0_valid(rv0[0]), .rsp0_ready(rr0[0]), .rsp1_valid(rv1[0]), .rsp1_ready(rr1[0]),
        .rsp_data(rd[0]), .busy(bsy[0]), .cnt0(c0_d0), .cnt1(c1_d0)
    );

    alu_arbiter #(.FAIR(1'b0), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset),
        .req0_valid(r0v[1]), .req0_ready(rdy0[1]), .req0_op(op0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
        .req1_valid(r1v[1]), .req1_ready(rdy1[1]), .req1_op(op1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
        .rsp0_valid(rv0[1]), .rsp0_ready(rr0[1]), .rsp1_valid(rv1[1]), .rsp1_ready(rr1[1]),
        .rsp_data(rd[1]), .busy(bsy[1]), .cnt0(c0_d1), .cnt1(c1_d1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a + 32'd1;
            3'd6:    return a - 32'd1;
            default: return b;
        endcase
    endfunction

    function automatic int get_cnt(input int d, input int n);
        if (d == 0) return (n == 0) ? int'(c0_d0) : int'(c1_d0);
        return (n == 0) ? int'(c0_d1) : int'(c1_d1);
    endfunction

    task automatic chk_counts(input int d, input string tag);
        chk({tag, "_cnt0"}, 64'(get_cnt(d, 0)), 64'(m_cnt0[d]));
        chk({tag, "_cnt1"}, 64'(get_cnt(d, 1)), 64'(m_cnt1[d]));
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge.
    task automatic txn(input int d, input bit v0, input bit v1,
                       input logic [2:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                       input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                       input int stall);
        int w;
        logic [31:0] exp_y;
        w = (v0 && v1) ? m_ptr[d] : (v1 ? 1 : 0);
        exp_y = (w == 1) ? alu_ref(o1, x1, y1) : alu_ref(o0, x0, y0);
        r0v[d] = v0; r1v[d] = v1;
        op0[d] = o0; a0[d] = x0; b0[d] = y0;
        op1[d] = o1; a1[d] = x1; b1[d] = y1;
        if (w == 0) begin rr0[d] = (stall == 0); rr1[d] = 1'($urandom_range(0, 1)); end
        else        begin rr1[d] = (stall == 0); rr0[d] = 1'($urandom_range(0, 1)); end
        #1;
        chk("grant", {62'd0, rdy1[d], rdy0[d]}, (w == 1) ? 64'd2 : 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (w == 0) r0v[d] = 1'b0; else r1v[d] = 1'b0;
        chk("exec_busy", 64'(bsy[d]), 64'd1);
        chk("exec_rsp", {62'd0, rv1[d], rv0[d]}, 64'd0);
        chk("exec_ready", {62'd0, rdy1[d], rdy0[d]}, 64'd0);
        @(negedge clk);
        for (int k = 0; k <= stall; k++) begin
            chk("resp_valid", {62'd0, rv1[d], rv0[d]}, (w == 1) ? 64'd2 : 64'd1);
            chk("resp_data", 64'(rd[d]), 64'(exp_y));
            chk("resp_busy", 64'(bsy[d]), 64'd1);
            chk("resp_ready", {62'd0, rdy1[d], rdy0[d]}, 64'd0);
            if (k < stall) @(negedge clk);
            else if (w == 0) rr0[d] = 1'b1;
            else rr1[d] = 1'b1;
        end
        @(posedge clk);
        if (w == 0) m_cnt0[d] = (m_cnt0[d] + 1) % m_mod[d];
        else        m_cnt1[d] = (m_cnt1[d] + 1) % m_mod[d];
        if (m_fair[d]) m_ptr[d] = 1 - w;
        @(negedge clk);
        chk_counts(d, "done");
        chk("done_rsp", {62'd0, rv1[d], rv0[d]}, 64'd0);
        chk("done_busy", 64'(bsy[d]), 64'd0);
        chk("hold_data", 64'(rd[d]), 64'(exp_y));
    endtask

    task automatic rand_txn(input int d);
        int v;
        v = $urandom_range(1, 3);
        txn(d, v[0], v[1], 3'($urandom), $urandom, $urandom,
            3'($urandom), $urandom, $urandom, $urandom_range(0, 2));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_cnt0[d] = 0; m_cnt1[d] = 0;
            r0v[d] = 1'b1; r1v[d] = 1'b1; rr0[d] = 1'b0; rr1[d] = 1'b0;
            op0[d] = 3'd1; op1[d] = 3'd1;
            a0[d] = 32'd0; b0[d] = 32'd0; a1[d] = 32'd0; b1[d] = 32'd0;
        end
        reset = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", {62'd0, rdy1[d], rdy0[d]}, 64'd0);
            chk("rst_rsp", {62'd0, rv1[d], rv0[d]}, 64'd0);
            chk("rst_busy", 64'(bsy[d]), 64'd0);
            chk("rst_data", 64'(rd[d]), 64'd0);
            chk_counts(d, "rst");
        end
        r0v = 2'b00; r1v = 2'b00;
        @(negedge clk);
        reset = 1'b0;

        // Reset pulse while a transaction sits in EXEC drops it silently.
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            r0v[d] = 1'b1; op0[d] = 3'd1; a0[d] = 32'd3; b0[d] = 32'd4; rr0[d] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            r0v[d] = 1'b0;
            chk("rexec_busy", 64'(bsy[d]), 64'd1);
            #1 reset = 1'b1;
            #1;
            chk("rexec_busy0", 64'(bsy[d]), 64'd0);
            chk("rexec_data0", 64'(rd[d]), 64'd0);
            chk("rexec_rsp0", {62'd0, rv1[d], rv0[d]}, 64'd0);
            #1 reset = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("rexec_norsp", {62'd0, rv1[d], rv0[d]}, 64'd0);
            end
            chk_counts(d, "rexec");
        end

        // Round-robin instance: single request, opcode sweep, contention, stall, random.
        txn(0, 1, 0, 3'd1, 32'd5, 32'd7, 3'd0, 32'd0, 32'd0, 0);
        chk("single_sum", 64'(rd[0]), 64'd12);
        for (int op = 0; op < 8; op++)
            txn(0, 0, 1, 3'd0, 32'd0, 32'd0, 3'(op), 32'hFFFF_FFFF, 32'd1, 0);
        for (int i = 0; i < 4; i++)
            txn(0, 1, 1, 3'd1, 32'(i), 32'd10, 3'd2, 32'(i), 32'd10, 0);
        txn(0, 1, 1, 3'd4, 32'hF0F0_0000, 32'h0000_0F0F, 3'd3, 32'd6, 32'd3, 5);
        txn(0, 0, 1, 3'd0, 32'd0, 32'd0, 3'd3, 32'd6, 32'd3, 0);
        for (int i = 0; i < 30; i++) rand_txn(0);

        // Fixed-priority instance with 2-bit counters: req0 always wins, cnt0 wraps.
        for (int i = 0; i < 5; i++)
            txn(1, 1, 1, 3'd5, 32'(i), 32'd0, 3'd6, 32'(i), 32'd0, 0);
        for (int i = 0; i < 15; i++) rand_txn(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
